// File: rtl/mem_access.sv
// Memory stage: bus handshake, lane steering and load extension.
// MEM_ACCESS_MISALIGN_TRAP_EN turns misaligned accesses into a trap.
module mem_access #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_aluout,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic              in_mem_en,
  input  logic              in_mem_wr,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic [4:0]        in_rd,
  input  logic              flush,
  output logic              dreq_valid,
  output logic [ADDR_W-1:0] dreq_addr,
  output logic [1:0]        dreq_size,
  output logic [7:0]        dreq_strobe,
  output logic [DATA_W-1:0] dreq_data,
  input  logic              dresp_addr_ok,
  input  logic              dresp_data_ok,
  input  logic [DATA_W-1:0] dresp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [4:0]        out_rd,
  output logic              out_wen,
  output logic              out_misalign
);

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, DONE, DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic              wr_q;
  logic [4:0]        rd_q;
  logic [DATA_W-1:0] result_q, result_d;
  logic              wen_q, wen_d;
  logic              mis_q, mis_d;

  logic              start;
  logic              fin;
  logic [2:0]        amask_in;
  logic [ADDR_W-1:0] aligned_in;
  logic [2:0]        off;
  logic [7:0]        smask;
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] ext;

  always_comb begin
    case (in_size)
      2'd0:    amask_in = 3'b000;
      2'd1:    amask_in = 3'b001;
      2'd2:    amask_in = 3'b011;
      default: amask_in = 3'b111;
    endcase
  end

  assign aligned_in = {in_aluout[ADDR_W-1:3],
                       in_aluout[2:0] & ~amask_in};

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  logic mis_in;
  assign mis_in = |(in_aluout[2:0] & amask_in);
`endif

  assign off = addr_q[2:0];

  always_comb begin
    case (size_q)
      2'd0:    smask = 8'h01;
      2'd1:    smask = 8'h03;
      2'd2:    smask = 8'h0F;
      default: smask = 8'hFF;
    endcase
  end

  // Bus fields come only from captured operands so they stay stable.
  assign dreq_valid  = (state_q == REQ);
  assign dreq_addr   = addr_q;
  assign dreq_size   = size_q;
  assign dreq_strobe = (dreq_valid && wr_q) ? (smask << off) : 8'h00;
  assign dreq_data   = wdata_q << {off, 3'b000};

  assign sh = dresp_data >> {off, 3'b000};

  always_comb begin
    case (size_q)
      2'd0:    ext = {{56{~uns_q & sh[7]}},  sh[7:0]};
      2'd1:    ext = {{48{~uns_q & sh[15]}}, sh[15:0]};
      2'd2:    ext = {{32{~uns_q & sh[31]}}, sh[31:0]};
      default: ext = sh;
    endcase
  end

  assign in_ready = (state_q == IDLE) ||
                    ((state_q == DONE) && out_ready);

  assign fin = dresp_data_ok && !flush &&
               (((state_q == REQ) && dresp_addr_ok) ||
                (state_q == WAIT));

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    wen_d    = wen_q;
    mis_d    = mis_q;
    start    = 1'b0;
    unique case (state_q)
      IDLE: start = in_valid && !flush;
      REQ: begin
        if (dresp_addr_ok) begin
          if (dresp_data_ok) state_d = flush ? IDLE : DONE;
          else               state_d = flush ? DRAIN : WAIT;
        end else if (flush) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (dresp_data_ok) state_d = flush ? IDLE : DONE;
        else if (flush)    state_d = DRAIN;
      end
      DONE: begin
        if (flush) begin
          state_d = IDLE;
        end else if (out_ready) begin
          state_d = IDLE;
          start   = in_valid;
        end
      end
      DRAIN: if (dresp_data_ok) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (fin) begin
      result_d = wr_q ? '0 : ext;
      wen_d    = ~wr_q;
      mis_d    = 1'b0;
    end
    if (start) begin
      if (!in_mem_en) begin
        state_d  = DONE;
        result_d = in_aluout;
        wen_d    = 1'b1;
        mis_d    = 1'b0;
      end
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
      else if (mis_in) begin
        state_d  = DONE;
        result_d = in_aluout;
        wen_d    = 1'b0;
        mis_d    = 1'b1;
      end
`endif
      else begin
        state_d = REQ;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      wr_q     <= 1'b0;
      rd_q     <= '0;
      result_q <= '0;
      wen_q    <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      wen_q    <= wen_d;
      mis_q    <= mis_d;
      if (start) begin
        addr_q  <= aligned_in;
        wdata_q <= in_wdata;
        size_q  <= in_size;
        uns_q   <= in_unsigned;
        wr_q    <= in_mem_wr;
        rd_q    <= in_rd;
      end
    end
  end

  assign out_valid    = (state_q == DONE);
  assign out_result   = result_q;
  assign out_rd       = rd_q;
  assign out_wen      = wen_q;
  assign out_misalign = mis_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: vector table, random ops vs. a
// transaction-level model, and hand-written corner sequences.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_aluout = '0;
  logic [63:0] in_wdata = '0;
  logic        in_mem_en = 1'b0;
  logic        in_mem_wr = 1'b0;
  logic [1:0]  in_size = '0;
  logic        in_unsigned = 1'b0;
  logic [4:0]  in_rd = '0;
  logic        flush = 1'b0;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [1:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok = 1'b0;
  logic        dresp_data_ok = 1'b0;
  logic [63:0] dresp_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_result;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic        out_misalign;

  mem_access dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_aluout(in_aluout), .in_wdata(in_wdata),
    .in_mem_en(in_mem_en), .in_mem_wr(in_mem_wr),
    .in_size(in_size), .in_unsigned(in_unsigned),
    .in_rd(in_rd), .flush(flush),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr),
    .dreq_size(dreq_size), .dreq_strobe(dreq_strobe),
    .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok),
    .dresp_data_ok(dresp_data_ok),
    .dresp_data(dresp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd),
    .out_wen(out_wen), .out_misalign(out_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a, wd, rdata;
    logic mem, wr, uns;
    logic [1:0] sz;
    logic [4:0] rd;
    int adly, ddly;
    logic trap;
    logic [63:0] eaddr, edata, eres;
    logic [7:0] estrb;
    logic ewen;
  } vec_t;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Reference: computes the access straight from the lane rules.
  function automatic vec_t mkref(
    input logic [63:0] a, wd, rdata, input logic mem, wr,
    input logic [1:0] sz, input logic uns, input logic [4:0] rd,
    input int adly, ddly);
    vec_t v;
    longint unsigned nb, off;
    logic [63:0] val, lim;
    logic [15:0] m;
    v.a = a; v.wd = wd; v.rdata = rdata; v.mem = mem;
    v.wr = wr; v.sz = sz; v.uns = uns; v.rd = rd;
    v.adly = adly; v.ddly = ddly; v.trap = 1'b0;
    v.eaddr = '0; v.edata = '0; v.eres = '0;
    v.estrb = '0; v.ewen = 1'b0;
    nb = 64'd1 << sz;
    if (!mem) begin
      v.eres = a; v.ewen = 1'b1;
      return v;
    end
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    if (a % nb != 0) begin
      v.trap = 1'b1; v.eres = a;
      return v;
    end
`endif
    v.eaddr = a - (a % nb);
    off = v.eaddr % 8;
    v.edata = wd << (8 * off);
    if (wr) begin
      m = ((16'd1 << nb) - 16'd1) << off;
      v.estrb = m[7:0];
    end else begin
      val = rdata >> (8 * off);
      if (nb < 8) begin
        lim = 64'd1 << (8 * nb);
        val = val % lim;
        if (!uns && val >= lim / 2) val = val - lim;
      end
      v.eres = val; v.ewen = 1'b1;
    end
    return v;
  endfunction

  function automatic vec_t mkv(
    input logic [63:0] a, wd, rdata, input logic mem, wr,
    input logic [1:0] sz, input logic uns, input int adly, ddly,
    input logic [63:0] eaddr, input logic [7:0] estrb,
    input logic [63:0] edata, eres, input logic ewen);
    vec_t v;
    v.a = a; v.wd = wd; v.rdata = rdata; v.mem = mem;
    v.wr = wr; v.sz = sz; v.uns = uns; v.rd = 5'd7;
    v.adly = adly; v.ddly = ddly; v.trap = 1'b0;
    v.eaddr = eaddr; v.estrb = estrb; v.edata = edata;
    v.eres = eres; v.ewen = ewen;
    return v;
  endfunction

  task automatic do_op(input vec_t v, input string t);
    chk({t, "_rdy"}, in_ready, 1);
    in_valid = 1'b1; in_aluout = v.a; in_wdata = v.wd;
    in_mem_en = v.mem; in_mem_wr = v.wr; in_size = v.sz;
    in_unsigned = v.uns; in_rd = v.rd;
    step();
    in_valid = 1'b0; in_aluout = rnd64(); in_wdata = rnd64();
    in_size = 2'($urandom); in_rd = 5'($urandom);
    if (v.mem && !v.trap) begin
      for (int i = 0; i <= v.adly; i++) begin
        chk({t, "_dvalid"}, dreq_valid, 1);
        chk({t, "_daddr"}, dreq_addr, v.eaddr);
        chk({t, "_dsize"}, dreq_size, v.sz);
        chk({t, "_dstrb"}, dreq_strobe, v.estrb);
        chk({t, "_ddata"}, dreq_data, v.edata);
        if (i == v.adly) begin
          dresp_addr_ok = 1'b1;
          dresp_data_ok = (v.ddly == 0);
          dresp_data = v.rdata;
        end
        step();
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
        dresp_data = rnd64();
      end
      for (int i = 1; i <= v.ddly; i++) begin
        chk({t, "_wait_dvalid"}, dreq_valid, 0);
        chk({t, "_wait_ovalid"}, out_valid, 0);
        if (i == v.ddly) begin
          dresp_data_ok = 1'b1; dresp_data = v.rdata;
        end
        step();
        dresp_data_ok = 1'b0; dresp_data = rnd64();
      end
    end else begin
      chk({t, "_nobus"}, dreq_valid, 0);
    end
    chk({t, "_ovalid"}, out_valid, 1);
    if (!(v.mem && v.wr && !v.trap))
      chk({t, "_result"}, out_result, v.eres);
    chk({t, "_wen"}, out_wen, v.ewen);
    chk({t, "_rd"}, out_rd, v.rd);
    chk({t, "_mis"}, out_misalign, v.trap);
    step();
    chk({t, "_idle"}, out_valid, 0);
  endtask

  vec_t tbl[11];
  vec_t rv;

  initial begin
    tbl[0]  = mkv(64'h1234, 0, 0, 0, 0, 2'd0, 0, 0, 0,
                  0, 8'h00, 0, 64'h1234, 1);
    tbl[1]  = mkv(64'h1003, 0, 64'h80000000, 1, 0, 2'd0, 0, 0, 0,
                  64'h1003, 8'h00, 0, 64'hFFFFFFFF_FFFFFF80, 1);
    tbl[2]  = mkv(64'h1003, 0, 64'h80000000, 1, 0, 2'd0, 1, 1, 2,
                  64'h1003, 8'h00, 0, 64'h80, 1);
    tbl[3]  = mkv(64'h2006, 64'hABCD, 0, 1, 1, 2'd1, 0, 3, 1,
                  64'h2006, 8'hC0, 64'hABCD0000_00000000, 0, 0);
    tbl[4]  = mkv(64'h3004, 0, 64'h87654321_00000000, 1, 0, 2'd2, 0,
                  0, 1, 64'h3004, 8'h00, 0,
                  64'hFFFFFFFF_87654321, 1);
    tbl[5]  = mkv(64'h4000, 0, 64'hF0E1D2C3_B4A59687, 1, 0, 2'd3, 1,
                  2, 0, 64'h4000, 8'h00, 0,
                  64'hF0E1D2C3_B4A59687, 1);
    tbl[6]  = mkv(64'h010A, 0, 64'h00000000_BEEF0000, 1, 0, 2'd1, 1,
                  0, 0, 64'h010A, 8'h00, 0, 64'hBEEF, 1);
    tbl[7]  = mkv(64'h5004, 64'h11223344, 0, 1, 1, 2'd2, 0, 1, 0,
                  64'h5004, 8'hF0, 64'h11223344_00000000, 0, 0);
    tbl[8]  = mkv(64'h6007, 64'h5A, 0, 1, 1, 2'd0, 0, 0, 2,
                  64'h6007, 8'h80, 64'h5A000000_00000000, 0, 0);
    tbl[9]  = mkv(64'h020E, 0, 64'h80010000_00000000, 1, 0, 2'd1, 0,
                  0, 0, 64'h020E, 8'h00, 0,
                  64'hFFFFFFFF_FFFF8001, 1);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    tbl[10] = mkv(64'h3002, 0, 64'h11111111_22222222, 1, 0, 2'd2, 0,
                  0, 0, 0, 8'h00, 0, 64'h3002, 0);
    tbl[10].trap = 1'b1;
`else
    tbl[10] = mkv(64'h3002, 0, 64'h11111111_22222222, 1, 0, 2'd2, 0,
                  0, 0, 64'h3000, 8'h00, 0, 64'h22222222, 1);
`endif

    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_dvalid", dreq_valid, 0);
    chk("rst_dstrb", dreq_strobe, 0);
    chk("rst_ovalid", out_valid, 0);
    chk("rst_result", out_result, 0);
    chk("rst_rd", out_rd, 0);
    chk("rst_wen", out_wen, 0);
    chk("rst_mis", out_misalign, 0);
    step();
    reset = 1'b1;
    step();

    for (int i = 0; i < 11; i++) do_op(tbl[i], $sformatf("vec%0d", i));

    // back-to-back pass-through, one per cycle
    in_valid = 1'b1; in_mem_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_aluout = 64'h1000 + 64'(i) * 64'h111; in_rd = 5'(i + 1);
      step();
      chk("b2b_valid", out_valid, 1);
      chk("b2b_result", out_result, 64'h1000 + 64'(i) * 64'h111);
      chk("b2b_rd", out_rd, 5'(i + 1));
    end
    in_valid = 1'b0;
    step();
    chk("b2b_end", out_valid, 0);

    // same-cycle addr/data ok, then 2-cycle writeback stall
    in_valid = 1'b1; in_mem_en = 1'b1; in_mem_wr = 1'b0;
    in_size = 2'd2; in_unsigned = 1'b0; in_aluout = 64'h3000;
    in_rd = 5'd9;
    step();
    in_valid = 1'b0;
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1;
    dresp_data = 64'hDEAD0000_7FFF0001;
    step();
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("stall_valid", out_valid, 1);
      chk("stall_result", out_result, 64'h7FFF0001);
      chk("stall_rdy", in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("stall_rel_rdy", in_ready, 1);
    step();
    chk("stall_idle", out_valid, 0);

    // flush while waiting for data, drain, then idle
    in_valid = 1'b1; in_aluout = 64'h100; in_size = 2'd2;
    step();
    in_valid = 1'b0; dresp_addr_ok = 1'b1;
    step();
    dresp_addr_ok = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0; #1;
    chk("drain_rdy", in_ready, 0);
    chk("drain_ovalid", out_valid, 0);
    step();
    chk("drain_rdy2", in_ready, 0);
    dresp_data_ok = 1'b1;
    step();
    dresp_data_ok = 1'b0; #1;
    chk("drain_done_rdy", in_ready, 1);
    chk("drain_done_ovalid", out_valid, 0);

    // flush in REQ before addr_ok
    in_valid = 1'b1; in_mem_wr = 1'b1; in_size = 2'd3;
    in_aluout = 64'h800;
    step();
    in_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0; #1;
    chk("fl_req_dvalid", dreq_valid, 0);
    chk("fl_req_rdy", in_ready, 1);
    chk("fl_req_ovalid", out_valid, 0);

    // flush beats a same-cycle accept in DONE
    in_valid = 1'b1; in_mem_en = 1'b0; in_aluout = 64'h77;
    step();
    flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0; #1;
    chk("fl_prio_ovalid", out_valid, 0);
    chk("fl_prio_dvalid", dreq_valid, 0);

    // asynchronous reset while a request is on the bus
    in_valid = 1'b1; in_mem_en = 1'b1; in_mem_wr = 1'b0;
    in_size = 2'd0; in_aluout = 64'h900;
    step();
    in_valid = 1'b0;
    chk("arst_pre", dreq_valid, 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_dvalid", dreq_valid, 0);
    chk("arst_rdy", in_ready, 1);
    step();
    reset = 1'b1;
    step();

    for (int i = 0; i < 150; i++) begin
      rv = mkref(rnd64(), rnd64(), rnd64(),
                 ($urandom_range(3) != 0), 1'($urandom),
                 2'($urandom), 1'($urandom), 5'($urandom),
                 $urandom_range(2), $urandom_range(2));
      do_op(rv, "rnd");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory stage, directly downstream of the execute ALU.
- Takes the 64-bit ALU result as the effective address (or as the pass-through result for non-memory ops) plus store data and memory-op control.
- Drives the data-bus request/response handshake.
- Aligns and extends load data, then presents a registered result to the writeback pipeline register.

Parameters:
- ADDR_W, 64, address width (ALU result width).
- DATA_W, 64, bus/register data width; fixed at 64, byte lanes = 8.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  execute stage has an op.
- in_ready  out  1  mem_access accepts the op this cycle.
- in_aluout  in  64  ALU result (address for mem ops, result otherwise).
- in_wdata  in  64  store data (rs2).
- in_mem_en  in  1  op is load/store.
- in_mem_wr  in  1  1=store, 0=load.
- in_size  in  2  0=B, 1=H, 2=W, 3=D.
- in_unsigned  in  1  zero-extend load.
- in_rd  in  5  destination register.
- flush  in  1  squash in-flight op.
- dreq_valid  out  1  bus request.
- dreq_addr  out  64  aligned-down-to-size address.
- dreq_size  out  2  access size.
- dreq_strobe  out  8  byte write enables (0 for loads).
- dreq_data  out  64  lane-shifted store data.
- dresp_addr_ok  in  1  request accepted.
- dresp_data_ok  in  1  response/data valid.
- dresp_data  in  64  raw 64-bit bus word.
- out_valid  out  1  result valid.
- out_ready  in  1  writeback accepts.
- out_result  out  64  final result.
- out_rd  out  5  destination register.
- out_wen  out  1  register write enable (0 for stores).
- out_misalign  out  1  address-misaligned exception.

Behaviour:
- Reset (async, reset=0): state=IDLE; in_ready=1; dreq_valid=0, dreq_strobe=0; out_valid=0, out_result=0, out_rd=0, out_wen=0, out_misalign=0.
- FSM states: IDLE, REQ, WAIT, DONE, DRAIN.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Accept when in_valid & in_ready. Operands are captured into internal registers; the bus is driven only from these registers.
- Non-memory op: out_result=in_aluout, out_wen=1; go to DONE (1-cycle latency).
- Memory op: go to REQ; dreq_valid=1 with all dreq_* stable until dresp_addr_ok.
- REQ & addr_ok & data_ok (same cycle): go to DONE.
- REQ & addr_ok only: go to WAIT.
- WAIT & data_ok: go to DONE.
- Store completes on data_ok; out_wen=0.
- Lane rules, with off = addr[2:0]:
  - dreq_strobe = size-mask (0x01/0x03/0x0F/0xFF) << off.
  - dreq_data = wdata << 8*off.
  - Load: shift dresp_data right by 8*off, take the low 8/16/32/64 bits, then sign- or zero-extend per in_unsigned. Doubleword ignores in_unsigned.
- DONE: out_valid=1 and outputs held until out_ready. out_ready with no new accept goes to IDLE. Accepting again in the same cycle goes to DONE/REQ per the new op.
- flush:
  - In IDLE, DONE or REQ-before-addr_ok: drop to IDLE next cycle; out_valid=0, dreq_valid=0.
  - In WAIT, or REQ coinciding with addr_ok: go to DRAIN. DRAIN waits for data_ok, discards the data, then goes to IDLE.
  - in_ready=0 in DRAIN.
  - flush has priority over a same-cycle accept.

Optional Feature:
- Macro: MEM_ACCESS_MISALIGN_TRAP_EN.
- Defined: if addr is not a multiple of the access size, no bus request is issued. The op goes to DONE next cycle with out_misalign=1, out_wen=0, out_result=address.
- Undefined: out_misalign is tied 0 and the address low bits below the size are forced to 0 (access silently aligned down).

Test Plan:
- ALU pass-through: in_aluout=0x1234, in_mem_en=0, out_ready=1 -> out_valid next cycle, out_result=0x1234, out_wen=1; back-to-back ops issue one per cycle.
- Signed byte load at addr 0x1003: dresp_data=0x00000000_80000000 -> out_result=0xFFFFFFFF_FFFFFF80. Same with in_unsigned=1 -> 0x80.
- Halfword store at 0x2006, wdata=0xABCD: dreq_strobe=0xC0, dreq_data=0xABCD0000_00000000; addr_ok delayed 3 cycles -> request held stable; out_wen=0.
- addr_ok and data_ok in the same cycle on a word load -> DONE in 1 cycle. out_ready=0 for 2 cycles -> outputs and out_valid held, in_ready=0.
- flush in WAIT, then data_ok two cycles later -> out_valid stays 0 and in_ready=1 only after the drain. Reset asserted in REQ -> dreq_valid drops immediately.
- With MEM_ACCESS_MISALIGN_TRAP_EN, word load at 0x3002 -> no dreq_valid, out_misalign=1. Without the macro -> dreq_addr=0x3000.
